// File: rtl/debug_clk_pkg.sv
// ---------------------------------------------------------------------------
// debug_clk_pkg
// Shared types and default parameters for the debug clock monitor.
//   mon_state_t  : monitor FSM state encoding
//   DEF_*        : default timing parameters for the monitored debug clock
// ---------------------------------------------------------------------------
package debug_clk_pkg;

    typedef enum logic [1:0] {
        MON_IDLE   = 2'd0,
        MON_TRACK  = 2'd1,
        MON_LOCKED = 2'd2,
        MON_LOST   = 2'd3
    } mon_state_t;

    localparam int DEF_EXP_HALF = 4;   // expected clk_ref cycles between clk_mon edges
    localparam int DEF_TOL      = 1;   // allowed deviation from DEF_EXP_HALF
    localparam int DEF_LOCK_CNT = 8;   // consecutive good measurements for lock
    localparam int DEF_TIMEOUT  = 16;  // edge-free cycles before loss

endpackage

// File: rtl/sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Synchronizes an asynchronous single-bit input into the clk domain and emits
// registered one-cycle pulses on its rising and falling edges.
// Ports:
//   clk    in  1  sampling clock
//   rst_n  in  1  asynchronous active-low reset
//   din    in  1  asynchronous input, sampled as data
//   rise   out 1  one-cycle pulse per rising edge of din
//   fall   out 1  one-cycle pulse per falling edge of din
// A new level is captured by sync[0] on clock edge 1 and the pulse is
// visible from clock edge SYNC_STG+1 (counting the capturing edge as 1).
// ---------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STG-1:0] sync;
    logic                dly;
    logic                last;

    assign last = sync[SYNC_STG-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            dly  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STG-2:0], din};
            dly  <= last;
            rise <= last & ~dly;
            fall <= ~last & dly;
        end
    end

endmodule

// File: rtl/debug_clk_monitor.sv
// ---------------------------------------------------------------------------
// debug_clk_monitor
// Receive-side checker for a debug divided clock. Detects clk_mon edges in
// the clk_ref domain, measures clk_ref cycles between successive edges,
// qualifies each measurement against EXP_HALF +/- TOL and reports lock,
// loss and a saturating error count.
// Ports:
//   clk_ref     in  1   reference clock
//   rst_n       in  1   asynchronous active-low reset
//   clk_mon     in  1   monitored clock (asynchronous, sampled as data)
//   clear_lost  in  1   one-cycle pulse clearing the sticky lost flag
//   rise_pulse  out 1   one-cycle pulse per detected rising edge
//   fall_pulse  out 1   one-cycle pulse per detected falling edge
//   half_period out CW  most recent measurement taken in TRACK/LOCKED
//   locked      out 1   registered copy of (state == MON_LOCKED)
//   lost        out 1   sticky loss flag
//   err_count   out 8   saturating count of bad measurements
//   mon_state   out 2   current FSM state (debug observation)
// ---------------------------------------------------------------------------
module debug_clk_monitor
    import debug_clk_pkg::*;
#(
    parameter  int EXP_HALF = DEF_EXP_HALF,
    parameter  int TOL      = DEF_TOL,
    parameter  int LOCK_CNT = DEF_LOCK_CNT,
    parameter  int TIMEOUT  = DEF_TIMEOUT,
    parameter  int SYNC_STG = 2,
    localparam int CW       = $clog2(TIMEOUT + 1)
) (
    input  logic          clk_ref,
    input  logic          rst_n,
    input  logic          clk_mon,
    input  logic          clear_lost,
    output logic          rise_pulse,
    output logic          fall_pulse,
    output logic [CW-1:0] half_period,
    output logic          locked,
    output logic          lost,
    output logic [7:0]    err_count,
    output mon_state_t    mon_state
);

    localparam int GW = $clog2(LOCK_CNT + 1);

    // Lower bound clamps at zero; upper bound cannot exceed the saturated
    // counter value, so it is clamped to TIMEOUT.
    localparam int LO_I = (EXP_HALF > TOL) ? (EXP_HALF - TOL) : 0;
    localparam int HI_I = ((EXP_HALF + TOL) > TIMEOUT) ? TIMEOUT : (EXP_HALF + TOL);

    localparam logic [CW-1:0] LO       = CW'(LO_I);
    localparam logic [CW-1:0] HI       = CW'(HI_I);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [GW-1:0] GOOD_TGT = GW'(LOCK_CNT);
    localparam logic [GW-1:0] GOOD_ONE = GW'(1);

    logic          edge_det;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [GW-1:0] good_cnt;
    logic [GW-1:0] good_next;
    logic [7:0]    err_next;
    logic [CW-1:0] hp_next;
    logic          lost_next;
    logic          timeout;
    logic          good;
    mon_state_t    state;
    mon_state_t    state_next;

    sync_edge_detect #(
        .SYNC_STG (SYNC_STG)
    ) u_sync_edge (
        .clk   (clk_ref),
        .rst_n (rst_n),
        .din   (clk_mon),
        .rise  (rise_pulse),
        .fall  (fall_pulse)
    );

    assign edge_det  = rise_pulse | fall_pulse;
    assign mon_state = state;

    // cnt holds the number of cycles since the last edge, so its value in an
    // edge cycle is the measurement for that edge.
    assign cnt_next = edge_det          ? CNT_ONE :
                      (cnt == CNT_MAX)  ? cnt     :
                                          cnt + CNT_ONE;

    assign timeout = (cnt == CNT_MAX);
    assign good    = (cnt >= LO) && (cnt <= HI);

    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        err_next   = err_count;
        hp_next    = half_period;
        case (state)
            MON_IDLE: begin
                // First edge only establishes a reference point.
                if (edge_det) begin
                    state_next = MON_TRACK;
                    good_next  = '0;
                end
            end
            MON_TRACK: begin
                if (timeout) begin
                    state_next = MON_LOST;
                end else if (edge_det) begin
                    hp_next = cnt;
                    if (good) begin
                        good_next = good_cnt + GOOD_ONE;
                        if (good_cnt + GOOD_ONE == GOOD_TGT) begin
                            state_next = MON_LOCKED;
                        end
                    end else begin
                        good_next = '0;
                        if (err_count != 8'hFF) err_next = err_count + 8'd1;
                    end
                end
            end
            MON_LOCKED: begin
                if (timeout) begin
                    state_next = MON_LOST;
                end else if (edge_det) begin
                    hp_next = cnt;
                    if (!good) begin
                        state_next = MON_TRACK;
                        good_next  = '0;
                        if (err_count != 8'hFF) err_next = err_count + 8'd1;
                    end
                end
            end
            MON_LOST: begin
                // The counter is saturated here, so this edge gives no
                // usable measurement; it only restarts tracking.
                if (edge_det) begin
                    state_next = MON_TRACK;
                    good_next  = '0;
                end
            end
            default: begin
                state_next = MON_IDLE;
            end
        endcase
    end

    // Entry into LOST has priority over a simultaneous clear request.
    always_comb begin
        lost_next = lost;
        if (state_next == MON_LOST && state != MON_LOST) begin
            lost_next = 1'b1;
        end else if (clear_lost) begin
            lost_next = 1'b0;
        end
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MON_IDLE;
            cnt         <= '0;
            good_cnt    <= '0;
            err_count   <= 8'd0;
            half_period <= '0;
            lost        <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            good_cnt    <= good_next;
            err_count   <= err_next;
            half_period <= hp_next;
            lost        <= lost_next;
            locked      <= (state == MON_LOCKED);
        end
    end

endmodule

// File: tb/tb_debug_clk_monitor.sv
// ---------------------------------------------------------------------------
// tb_debug_clk_monitor
// Directed bench for debug_clk_monitor: a table of steady half-period runs
// plus hand-written sequences for edge latency, timeout/loss, glitch
// recovery, error saturation and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_debug_clk_monitor;
    import debug_clk_pkg::*;

    localparam int CW = $clog2(DEF_TIMEOUT + 1);

    logic          clk_ref;
    logic          rst_n;
    logic          clk_mon;
    logic          clear_lost;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [CW-1:0] half_period;
    logic          locked;
    logic          lost;
    logic [7:0]    err_count;
    mon_state_t    mon_state;

    int n_total = 0;
    int n_pass  = 0;
    int rise_seen = 0;
    int fall_seen = 0;

    debug_clk_monitor dut (
        .clk_ref     (clk_ref),
        .rst_n       (rst_n),
        .clk_mon     (clk_mon),
        .clear_lost  (clear_lost),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .half_period (half_period),
        .locked      (locked),
        .lost        (lost),
        .err_count   (err_count),
        .mon_state   (mon_state)
    );

    // ---------------- clock / reset ----------------
    initial clk_ref = 1'b0;
    always #5 clk_ref = ~clk_ref;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk_ref) begin
        if (rise_pulse) rise_seen = rise_seen + 1;
        if (fall_pulse) fall_seen = fall_seen + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        rst_n      = 1'b0;
        clk_mon    = 1'b0;
        clear_lost = 1'b0;
        repeat (3) @(negedge clk_ref);
        rst_n = 1'b1;
    endtask

    // n toggles of clk_mon, each h clk_ref cycles after the previous one.
    task automatic run_edges(input int h, input int n);
        for (int i = 0; i < n; i++) begin
            repeat (h) @(negedge clk_ref);
            clk_mon = ~clk_mon;
        end
    endtask

    task automatic settle();
        repeat (6) @(negedge clk_ref);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int act, input int exp);
        n_total = n_total + 1;
        if (act == exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int half;
        int edges;
        int exp_locked;
        int exp_err;
        int exp_hp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int r0;
        int f0;

        // half, edges, locked, err_count, half_period
        vecs[0] = '{4,  9, 1,  0, 4};
        vecs[1] = '{4,  8, 0,  0, 4};   // only 7 good measurements
        vecs[2] = '{6, 10, 0,  9, 6};
        vecs[3] = '{5,  9, 1,  0, 5};   // upper tolerance bound
        vecs[4] = '{3,  9, 1,  0, 3};   // lower tolerance bound
        vecs[5] = '{2, 12, 0, 11, 2};   // just below tolerance
        vecs[6] = '{1,  6, 0,  5, 1};
        vecs[7] = '{7,  5, 0,  4, 7};

        // ---- reset state ----
        reset_dut();
        check("rst_rise",   int'(rise_pulse),  0);
        check("rst_fall",   int'(fall_pulse),  0);
        check("rst_hp",     int'(half_period), 0);
        check("rst_locked", int'(locked),      0);
        check("rst_lost",   int'(lost),        0);
        check("rst_err",    int'(err_count),   0);
        check("rst_state",  int'(mon_state),   int'(MON_IDLE));

        // ---- edge pulse latency: visible from the 3rd sampling edge ----
        @(negedge clk_ref);
        clk_mon = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk_ref);
            #1;
            check($sformatf("rise_lat_k%0d", k), int'(rise_pulse), (k == 3) ? 1 : 0);
        end
        @(negedge clk_ref);
        clk_mon = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk_ref);
            #1;
            check($sformatf("fall_lat_k%0d", k), int'(fall_pulse), (k == 3) ? 1 : 0);
        end

        // ---- table-driven steady runs ----
        for (int v = 0; v < 8; v++) begin
            reset_dut();
            r0 = rise_seen;
            f0 = fall_seen;
            run_edges(vecs[v].half, vecs[v].edges);
            settle();
            check($sformatf("v%0d_locked", v), int'(locked),      vecs[v].exp_locked);
            check($sformatf("v%0d_err", v),    int'(err_count),   vecs[v].exp_err);
            check($sformatf("v%0d_hp", v),     int'(half_period), vecs[v].exp_hp);
            check($sformatf("v%0d_lost", v),   int'(lost),        0);
            check($sformatf("v%0d_rises", v),  rise_seen - r0,    (vecs[v].edges + 1) / 2);
            check($sformatf("v%0d_falls", v),  fall_seen - f0,    vecs[v].edges / 2);
        end

        // ---- lock, stop clk_mon, loss after TIMEOUT, clear, relock ----
        reset_dut();
        run_edges(4, 9);
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk_ref);
            #1;
            if (k == 10) check("stop_locked_before", int'(locked), 1);
            if (k == 19) check("stop_lost_k19",      int'(lost),   0);
            if (k == 20) check("stop_lost_k20",      int'(lost),   1);
            if (k == 21) check("stop_locked_k21",    int'(locked), 0);
        end
        check("stop_state", int'(mon_state), int'(MON_LOST));
        repeat (5) @(negedge clk_ref);
        clear_lost = 1'b1;
        @(negedge clk_ref);
        clear_lost = 1'b0;
        check("clear_lost",       int'(lost),      0);
        check("clear_state_lost", int'(mon_state), int'(MON_LOST));
        run_edges(4, 9);
        settle();
        check("relock_locked", int'(locked),    1);
        check("relock_lost",   int'(lost),      0);
        check("relock_err",    int'(err_count), 0);

        // ---- clear_lost coinciding with entry into LOST ----
        reset_dut();
        run_edges(4, 9);
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk_ref);
        end
        #1;
        check("coinc_lost_k19", int'(lost), 0);
        @(negedge clk_ref);
        clear_lost = 1'b1;
        @(posedge clk_ref);
        #1;
        check("coinc_set_wins", int'(lost), 1);
        @(negedge clk_ref);
        clear_lost = 1'b0;
        @(posedge clk_ref);
        #1;
        check("coinc_lost_held", int'(lost), 1);

        // ---- single glitch while locked ----
        reset_dut();
        run_edges(4, 9);
        run_edges(2, 1);
        run_edges(4, 2);
        check("glitch_locked", int'(locked),    0);
        check("glitch_err",    int'(err_count), 1);
        run_edges(4, 6);
        settle();
        check("glitch_relock", int'(locked),      1);
        check("glitch_err2",   int'(err_count),   1);
        check("glitch_hp",     int'(half_period), 4);

        // ---- error counter saturation ----
        reset_dut();
        run_edges(6, 255);
        settle();
        check("sat_err_254", int'(err_count), 254);
        run_edges(6, 1);
        settle();
        check("sat_err_255", int'(err_count), 255);
        run_edges(6, 44);
        settle();
        check("sat_err_hold", int'(err_count), 255);
        check("sat_locked",   int'(locked),    0);

        // ---- asynchronous reset mid-lock ----
        reset_dut();
        run_edges(4, 9);
        run_edges(2, 1);
        run_edges(4, 9);
        settle();
        check("arst_pre_locked", int'(locked),    1);
        check("arst_pre_err",    int'(err_count), 1);
        @(posedge clk_ref);
        #3;
        rst_n   = 1'b0;
        clk_mon = 1'b0;
        #1;
        check("arst_locked", int'(locked),      0);
        check("arst_err",    int'(err_count),   0);
        check("arst_hp",     int'(half_period), 0);
        check("arst_state",  int'(mon_state),   int'(MON_IDLE));
        repeat (2) @(negedge clk_ref);
        rst_n = 1'b1;
        run_edges(4, 2);
        check("arst_first_discard_hp", int'(half_period), 0);
        check("arst_first_state",      int'(mon_state),   int'(MON_TRACK));
        run_edges(4, 7);
        settle();
        check("arst_relock", int'(locked),      1);
        check("arst_hp4",    int'(half_period), 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
